// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-access sequencer: funct3 size codes, FSM
// state encoding and request-legality helpers.
package mem_access_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    MA_IDLE  = 2'd0,
    MA_REQ   = 2'd1,
    MA_DONE  = 2'd2,
    MA_FAULT = 2'd3
  } ma_state_e;

  // Fetches are always word reads, so their funct3 field is never checked.
  function automatic logic f3_legal(input logic       we,
                                    input logic       fetch,
                                    input logic [2:0] f3);
    if (fetch) return 1'b1;
    if (we)    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic is_misaligned(input logic       fetch,
                                         input logic [2:0] f3,
                                         input logic [1:0] addr_lo);
    if (fetch) return addr_lo != 2'b00;
    case (f3)
      F3_H, F3_HU: return addr_lo[0];
      F3_W:        return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Load-data lane selection and sign/zero extension for loads and fetches.
module mem_access_ctrl_load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] i_rdata_raw,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic        i_is_fetch,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata_raw[7:0];
      2'd1:    w_byte = i_rdata_raw[15:8];
      2'd2:    w_byte = i_rdata_raw[23:16];
      default: w_byte = i_rdata_raw[31:24];
    endcase
    // Halfword lane depends only on addr[1]; addr[0] is ignored here.
    w_half = i_addr_lo[1] ? i_rdata_raw[31:16] : i_rdata_raw[15:0];
  end

  always_comb begin
    o_rdata = i_rdata_raw;
    if (!i_is_fetch) begin
      case (i_funct3)
        F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
        F3_BU:   o_rdata = {24'd0, w_byte};
        F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
        F3_HU:   o_rdata = {16'd0, w_half};
        default: o_rdata = i_rdata_raw;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-access sequencer: one-cycle FSM request -> valid/ready bus access.
// Optional misalignment faulting is enabled by defining MISALIGN_CHECK_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic        is_fetch,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ma_state_e   r_state;
  ma_state_e   w_next;
  logic        r_we;
  logic        r_fetch;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_bad_req;
  logic        w_is_store;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

  assign w_accept   = (r_state == MA_IDLE) && mem_req;
  assign w_is_store = mem_we && !is_fetch;

`ifdef MISALIGN_CHECK_EN
  assign w_bad_req = !f3_legal(w_is_store, is_fetch, funct3) ||
                     is_misaligned(is_fetch, funct3, addr[1:0]);
`else
  assign w_bad_req = !f3_legal(w_is_store, is_fetch, funct3);
`endif

  // Store lanes are resolved once at acceptance so the bus sees stable values.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = wdata;
    if (w_is_store) begin
      case (funct3)
        F3_B: begin
          w_wstrb = 4'b0001 << addr[1:0];
          w_wdata = {4{wdata[7:0]}};
        end
        F3_H: begin
          w_wstrb = addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{wdata[15:0]}};
        end
        F3_W:    w_wstrb = 4'b1111;
        default: w_wstrb = 4'b0000;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= MA_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      MA_IDLE: begin
        if (mem_req) w_next = w_bad_req ? MA_FAULT : MA_REQ;
      end
      MA_REQ: begin
        if (bus_ready)                 w_next = MA_DONE;
        else if (r_cnt == LP_CNT_LAST) w_next = MA_FAULT;
      end
      MA_DONE:  w_next = MA_IDLE;
      MA_FAULT: w_next = MA_IDLE;
      default:  w_next = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_fetch <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'b0000;
    end else if (w_accept) begin
      r_we    <= w_is_store;
      r_fetch <= is_fetch;
      r_f3    <= funct3;
      r_addr  <= addr;
      r_wdata <= w_wdata;
      r_wstrb <= w_wstrb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   r_cnt <= '0;
    else if ((r_state == MA_REQ) && !bus_ready) r_cnt <= r_cnt + CNT_W'(1);
    else                                        r_cnt <= '0;
  end

  mem_access_ctrl_load_extend u_load_extend (
    .i_rdata_raw (bus_rdata),
    .i_addr_lo   (r_addr[1:0]),
    .i_funct3    (r_f3),
    .i_is_fetch  (r_fetch),
    .o_rdata     (w_ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  r_rdata <= 32'd0;
    else if ((r_state == MA_REQ) && bus_ready) r_rdata <= w_ext;
  end

  // Bus fields are gated by bus_valid so the bus is quiet outside REQ.
  always_comb begin
    busy      = (r_state != MA_IDLE);
    done      = (r_state == MA_DONE);
    fault     = (r_state == MA_FAULT);
    bus_valid = (r_state == MA_REQ);
    bus_we    = bus_valid && r_we;
    bus_addr  = bus_valid ? {r_addr[31:2], 2'b00} : 32'd0;
    bus_wstrb = bus_valid ? r_wstrb : 4'b0000;
    bus_wdata = bus_valid ? r_wdata : 32'd0;
    rdata     = r_rdata;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; optional build with
// MISALIGN_CHECK_EN defined changes the misaligned-access expectations.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic        is_fetch;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .is_fetch  (is_fetch),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .rdata     (rdata),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wstrb (bus_wstrb),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  // Drives a one-cycle request; returns 1 time unit after the accepting edge.
  task automatic start_req(input logic we, input logic fetch, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    mem_we   = we;
    is_fetch = fetch;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    mem_req  = 1'b1;
    @(posedge clk); #1;
    mem_req  = 1'b0;
  endtask

  // Runs one access and reports the outcome; o_lat counts cycles after the request cycle.
  task automatic run_access(input logic we, input logic fetch, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic o_done, output logic o_fault,
                            output logic o_saw_valid, output logic [31:0] o_rdata,
                            output int o_lat);
    bit finished = 0;
    o_done = 0; o_fault = 0; o_saw_valid = 0; o_rdata = '0; o_lat = 0;
    start_req(we, fetch, f3, a, wd);
    for (int i = 0; i < 40 && !finished; i++) begin
      if (bus_valid) o_saw_valid = 1'b1;
      if (done || fault) begin
        o_done = done; o_fault = fault; o_rdata = rdata; o_lat = i + 1;
        finished = 1;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; mem_req = 0; mem_we = 0; is_fetch = 0; funct3 = 0;
    addr = 0; wdata = 0; bus_ready = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, fault, bus_valid, bus_we} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, fault, bus_valid, bus_we});
    end
    n_cmp++;
    if ({rdata, bus_addr, bus_wdata, bus_wstrb} !== '0) begin
      n_err++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h wstrb=%b want all 0",
                        rdata, bus_addr, bus_wdata, bus_wstrb);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_lw_latency;
    bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
    start_req(1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
    n_cmp++;
    if ({bus_valid, bus_we, bus_wstrb, done} !== 7'b1_0_0000_0) begin
      n_err++; $display("FAIL lw_n1_ctrl: valid/we/wstrb/done got %b want 1000000",
                        {bus_valid, bus_we, bus_wstrb, done});
    end
    n_cmp++;
    if (bus_addr !== 32'h100) begin
      n_err++; $display("FAIL lw_n1_addr: got %h want 00000100", bus_addr);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done, bus_valid} !== 2'b10) begin
      n_err++; $display("FAIL lw_n2_done: done/valid got %b want 10", {done, bus_valid});
    end
    n_cmp++;
    if (rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL lw_rdata: got %h want deadbeef", rdata);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_err++; $display("FAIL lw_n3_idle: done/busy got %b want 00", {done, busy});
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3_t   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b111};
    logic [31:0] a_t    [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
    logic        ftch_t [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_t  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                                32'h000080FF, 32'h80FF0000};
    logic d, f, v;
    logic [31:0] r;
    int lat;
    bus_ready = 1'b1; bus_rdata = 32'h80FF0000;
    for (int i = 0; i < 5; i++) begin
      run_access(1'b0, ftch_t[i], f3_t[i], a_t[i], 32'h0, d, f, v, r, lat);
      n_cmp++;
      if ({d, f, lat == 2} !== 3'b101 || r !== exp_t[i]) begin
        n_err++; $display("FAIL load_%0d: done=%b fault=%b lat=%0d rdata=%h want done=1 fault=0 lat=2 rdata=%h",
                          i, d, f, lat, r, exp_t[i]);
      end
    end
  endtask

  task automatic test_stores;
    logic [2:0]  f3_t [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] a_t  [3] = '{32'h202, 32'h201, 32'h20C};
    logic [31:0] wd_t [3] = '{32'h00001234, 32'h000000AB, 32'h01234567};
    logic [3:0]  sb_t [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ew_t [3] = '{32'h12341234, 32'hABABABAB, 32'h01234567};
    logic [31:0] ea_t [3] = '{32'h200, 32'h200, 32'h20C};
    bus_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_req(1'b1, 1'b0, f3_t[i], a_t[i], wd_t[i]);
      n_cmp++;
      if ({bus_valid, bus_we} !== 2'b11 || bus_wstrb !== sb_t[i] ||
          bus_wdata !== ew_t[i] || bus_addr !== ea_t[i]) begin
        n_err++; $display("FAIL store_%0d: valid=%b we=%b wstrb=%b wdata=%h addr=%h want 1 1 %b %h %h",
                          i, bus_valid, bus_we, bus_wstrb, bus_wdata, bus_addr, sb_t[i], ew_t[i], ea_t[i]);
      end
      bus_ready = 1'b1;
      @(posedge clk); #1;
      bus_ready = 1'b0;
      n_cmp++;
      if (done !== 1'b1) begin
        n_err++; $display("FAIL store_%0d_done: got %b want 1", i, done);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wait_states;
    bit stable = 1;
    bus_ready = 1'b0; bus_rdata = 32'h5555AAAA;
    start_req(1'b0, 1'b0, 3'b010, 32'h300, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (bus_valid !== 1'b1 || bus_addr !== 32'h300 || done !== 1'b0) stable = 0;
      if (i == 1) begin addr = 32'h400; mem_req = 1'b1; end
      @(posedge clk); #1;
      mem_req = 1'b0;
    end
    bus_ready = 1'b1;
    if (bus_valid !== 1'b1 || bus_addr !== 32'h300 || done !== 1'b0) stable = 0;
    n_cmp++;
    if (!stable) begin
      n_err++; $display("FAIL wait_stable: valid=%b addr=%h done=%b want 1 00000300 0",
                        bus_valid, bus_addr, done);
    end
    @(posedge clk); #1;
    bus_ready = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || rdata !== 32'h5555AAAA) begin
      n_err++; $display("FAIL wait_done: done=%b rdata=%h want 1 5555aaaa", done, rdata);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, bus_valid} !== 2'b00) begin
      n_err++; $display("FAIL wait_no_queue: busy/valid got %b want 00", {busy, bus_valid});
    end
  endtask

  task automatic test_timeout;
    int  valid_cycles = 0;
    bit  seen = 0;
    logic valid_at_fault = 1'b1;
    bus_ready = 1'b0;
    start_req(1'b0, 1'b0, 3'b010, 32'h500, 32'h0);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (fault) begin
        seen = 1; valid_at_fault = bus_valid;
      end else begin
        if (bus_valid) valid_cycles++;
        @(posedge clk); #1;
      end
    end
    n_cmp++;
    if (!seen || valid_cycles != 16 || valid_at_fault !== 1'b0) begin
      n_err++; $display("FAIL timeout: seen=%0d valid_cycles=%0d valid_at_fault=%b want 1 16 0",
                        seen, valid_cycles, valid_at_fault);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, fault, done} !== 3'b000) begin
      n_err++; $display("FAIL timeout_after: busy/fault/done got %b want 000", {busy, fault, done});
    end
  endtask

  task automatic test_illegal;
    logic       we_t [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0] f3_t [3] = '{3'b011, 3'b110, 3'b100};
    logic d, f, v;
    logic [31:0] r;
    int lat;
    bus_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_access(we_t[i], 1'b0, f3_t[i], 32'h600, 32'h0, d, f, v, r, lat);
      n_cmp++;
      if ({d, f, v} !== 3'b010 || lat != 1) begin
        n_err++; $display("FAIL illegal_%0d: done=%b fault=%b saw_valid=%b lat=%0d want 0 1 0 1",
                          i, d, f, v, lat);
      end
    end
  endtask

  task automatic test_misalign;
    logic d, f, v;
    logic [31:0] r;
    int lat;
    bus_ready = 1'b1; bus_rdata = 32'hCAFEF00D;
    run_access(1'b0, 1'b0, 3'b010, 32'h101, 32'h0, d, f, v, r, lat);
`ifdef MISALIGN_CHECK_EN
    n_cmp++;
    if ({d, f, v} !== 3'b010 || lat != 1) begin
      n_err++; $display("FAIL misalign_lw: done=%b fault=%b saw_valid=%b lat=%0d want 0 1 0 1", d, f, v, lat);
    end
`else
    n_cmp++;
    if ({d, f} !== 2'b10 || r !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL misalign_lw: done=%b fault=%b rdata=%h want 1 0 cafef00d", d, f, r);
    end
    run_access(1'b0, 1'b0, 3'b001, 32'h103, 32'h0, d, f, v, r, lat);
    n_cmp++;
    if ({d, f} !== 2'b10 || r !== 32'hFFFFCAFE) begin
      n_err++; $display("FAIL misalign_lh: done=%b fault=%b rdata=%h want 1 0 ffffcafe", d, f, r);
    end
`endif
  endtask

  task automatic test_reset_mid;
    bit pulse = 0;
    bus_ready = 1'b0;
    start_req(1'b1, 1'b0, 3'b010, 32'h700, 32'h87654321);
    n_cmp++;
    if (bus_valid !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: valid got %b want 1", bus_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, fault, bus_valid, bus_we, bus_wstrb} !== 9'b0 ||
        bus_addr !== 32'h0 || bus_wdata !== 32'h0 || rdata !== 32'h0) begin
      n_err++; $display("FAIL rstmid_async: busy=%b valid=%b we=%b wstrb=%b addr=%h wdata=%h rdata=%h want all 0",
                        busy, bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata, rdata);
    end
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done || fault || busy) pulse = 1;
    end
    n_cmp++;
    if (pulse) begin
      n_err++; $display("FAIL rstmid_after: stray done/fault/busy seen want none");
    end
  endtask

  initial begin
    test_reset();
    test_lw_latency();
    test_loads();
    test_stores();
    test_wait_states();
    test_timeout();
    test_illegal();
    test_misalign();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
